// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path: FSM state
// encoding, opcodes and the error display word.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        ERROR  = 3'd4
    } state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd4;

    localparam logic [15:0] ERR_BCD = 16'hEEEE;

endpackage

// File: rtl/btn_sync_edge.sv
// Brings an asynchronous button level into the clk domain through two flops
// and flags its rising edge with a third.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = btn_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM between the operand switches/button and the calculator datapath:
// captures operands, launches one BCD conversion and holds the display word.
module calc_sequencer #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [15:0] ERR_BCD        = calc_pkg::ERR_BCD,
    parameter logic [2:0]  OP_DIV         = calc_pkg::OP_DIV,
    parameter logic [2:0]  OP_MAX         = calc_pkg::OP_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    input  logic [2:0]  op,
    output logic [3:0]  a_q,
    output logic [3:0]  b_q,
    output logic [2:0]  op_q,
    input  logic [7:0]  result,
    output logic        conv_start,
    output logic [15:0] conv_bin,
    input  logic        conv_rdy,
    input  logic [15:0] conv_bcd,
    output logic [15:0] disp_bcd,
    output logic        disp_valid,
    output logic        busy,
    output logic        err
);

    import calc_pkg::*;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic go_rise;

    btn_sync_edge u_go_sync (
        .clk    (clk),
        .reset  (reset),
        .btn_in (go),
        .rise   (go_rise)
    );

    state_e           state_q, state_d;
    logic [3:0]       a_d, b_d;
    logic [2:0]       op_d;
    logic             conv_start_q, conv_start_d;
    logic [15:0]      conv_bin_q, conv_bin_d;
    logic [15:0]      disp_bcd_q, disp_bcd_d;
    logic             disp_valid_q, disp_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        conv_start_d = 1'b0;
        conv_bin_d   = conv_bin_q;
        disp_bcd_d   = disp_bcd_q;
        disp_valid_d = disp_valid_q;
        busy_d       = busy_q;
        err_d        = err_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (go_rise) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if ((op_q > OP_MAX) || ((op_q == OP_DIV) && (b_q == 4'd0))) begin
                    state_d = ERROR;
                end else begin
                    conv_bin_d   = {8'b0, result};
                    conv_start_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // Saturate rather than wrap; leaving WAIT at CNT_LAST is guaranteed.
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (conv_rdy) begin
                    disp_bcd_d   = conv_bcd;
                    disp_valid_d = 1'b1;
                    err_d        = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                disp_bcd_d   = ERR_BCD;
                disp_valid_d = 1'b1;
                err_d        = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                // LAUNCH is reserved; recover to IDLE if ever reached.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            conv_start_q <= 1'b0;
            conv_bin_q   <= '0;
            disp_bcd_q   <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            conv_start_q <= conv_start_d;
            conv_bin_q   <= conv_bin_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign conv_start = conv_start_q;
    assign conv_bin   = conv_bin_q;
    assign disp_bcd   = disp_bcd_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small arithmetic-unit model and a
// converter model whose rdy latency is set per step.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [3:0]  a, b;
    logic [2:0]  op;
    logic [3:0]  a_q, b_q;
    logic [2:0]  op_q;
    logic [7:0]  result;
    logic        conv_start;
    logic [15:0] conv_bin;
    logic        conv_rdy;
    logic [15:0] conv_bcd;
    logic [15:0] disp_bcd;
    logic        disp_valid;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    calc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .a          (a),
        .b          (b),
        .op         (op),
        .a_q        (a_q),
        .b_q        (b_q),
        .op_q       (op_q),
        .result     (result),
        .conv_start (conv_start),
        .conv_bin   (conv_bin),
        .conv_rdy   (conv_rdy),
        .conv_bcd   (conv_bcd),
        .disp_bcd   (disp_bcd),
        .disp_valid (disp_valid),
        .busy       (busy),
        .err        (err)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // arithmetic unit model
    always_comb begin
        result = 8'd0;
        case (op_q)
            OP_ADD:  result = {4'b0, a_q} + {4'b0, b_q};
            OP_SUB:  result = {4'b0, a_q} - {4'b0, b_q};
            OP_MUL:  result = {4'b0, a_q} * {4'b0, b_q};
            OP_DIV:  result = (b_q != 0) ? {4'b0, a_q / b_q} : 8'd0;
            OP_MOD:  result = (b_q != 0) ? {4'b0, a_q % b_q} : 8'd0;
            default: result = 8'd0;
        endcase
    end

    function automatic logic [15:0] to_bcd(input logic [15:0] v);
        int n;
        n = int'(v);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // converter model: rdy for one cycle conv_delay cycles after the start
    // cycle; conv_delay == 0 means the converter never answers
    int          conv_delay = 0;
    int          cd = 0;
    logic        cv_active = 1'b0;
    logic [15:0] bin_l = '0;
    int          start_cnt = 0;
    int          rdy_cnt = 0;

    initial begin
        conv_rdy = 1'b0;
        conv_bcd = '0;
    end

    always @(posedge clk) begin
        conv_rdy <= 1'b0;
        if (cv_active) begin
            if (cd == 1) begin
                conv_rdy  <= 1'b1;
                conv_bcd  <= to_bcd(bin_l);
                cv_active <= 1'b0;
                rdy_cnt   <= rdy_cnt + 1;
            end else begin
                cd <= cd - 1;
            end
        end
        if (conv_start) begin
            start_cnt <= start_cnt + 1;
            if (conv_delay == 1) begin
                conv_rdy <= 1'b1;
                conv_bcd <= to_bcd(conv_bin);
                rdy_cnt  <= rdy_cnt + 1;
            end else if (conv_delay > 1) begin
                cv_active <= 1'b1;
                cd        <= conv_delay - 1;
                bin_l     <= conv_bin;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // raise go, optionally drop it after one cycle, and count cycles to busy
    task automatic press(input bit hold, output int n);
        go = 1'b1;
        n  = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
            if (!hold) go = 1'b0;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic set_ops(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] opv);
        a  = av;
        b  = bv;
        op = opv;
    endtask

    int n;
    int s0;
    int r0;

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        set_ops(4'd0, 4'd0, 3'd0);
        repeat (3) tick();
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_valid", 16'(disp_valid), 16'd0);
        check("rst_disp", disp_bcd, 16'h0000);
        check("rst_start", 16'(conv_start), 16'd0);
        reset = 1'b0;
        tick();

        // 7 + 5, rdy two cycles after the start pulse
        set_ops(4'd7, 4'd5, OP_ADD);
        conv_delay = 2;
        s0 = start_cnt;
        press(1'b0, n);
        check("add_press_lat", 16'(n), 16'd3);
        check("add_settle_start", 16'(conv_start), 16'd0);
        tick();
        check("add_start_hi", 16'(conv_start), 16'd1);
        check("add_conv_bin", conv_bin, 16'h000C);
        check("add_aq", 16'({a_q, b_q, 1'b0, op_q}), 16'({4'd7, 4'd5, 1'b0, OP_ADD}));
        tick();
        check("add_start_lo", 16'(conv_start), 16'd0);
        tick();
        check("add_busy_wait", 16'(busy), 16'd1);
        tick();
        check("add_busy_done", 16'(busy), 16'd0);
        check("add_disp", disp_bcd, 16'h0012);
        check("add_valid", 16'(disp_valid), 16'd1);
        check("add_err", 16'(err), 16'd0);
        check("add_nstart", 16'(start_cnt - s0), 16'd1);

        // divide by zero
        set_ops(4'd9, 4'd0, OP_DIV);
        s0 = start_cnt;
        press(1'b0, n);
        check("dz_disp_hold", disp_bcd, 16'h0012);
        wait_idle(n);
        check("dz_busy_cycles", 16'(n + 1), 16'd3);
        check("dz_disp", disp_bcd, 16'hEEEE);
        check("dz_err", 16'(err), 16'd1);
        check("dz_valid", 16'(disp_valid), 16'd1);
        check("dz_nstart", 16'(start_cnt - s0), 16'd0);

        // illegal opcode, then a legal add clears err
        set_ops(4'd1, 4'd1, 3'b110);
        s0 = start_cnt;
        press(1'b0, n);
        wait_idle(n);
        check("ill_busy_cycles", 16'(n), 16'd2);
        check("ill_disp", disp_bcd, 16'hEEEE);
        check("ill_err", 16'(err), 16'd1);
        check("ill_nstart", 16'(start_cnt - s0), 16'd0);
        set_ops(4'd3, 4'd4, OP_ADD);
        conv_delay = 1;
        press(1'b0, n);
        check("add7_disp_hold", disp_bcd, 16'hEEEE);
        wait_idle(n);
        check("add7_lat", 16'(n), 16'd3);
        check("add7_disp", disp_bcd, 16'h0007);
        check("add7_err", 16'(err), 16'd0);

        // legal divide 9 / 3
        set_ops(4'd9, 4'd3, OP_DIV);
        press(1'b0, n);
        wait_idle(n);
        check("div_disp", disp_bcd, 16'h0003);
        check("div_err", 16'(err), 16'd0);

        // converter never answers: ERROR 64 cycles after the start cycle
        set_ops(4'd1, 4'd1, OP_ADD);
        conv_delay = 0;
        press(1'b0, n);
        tick();
        check("to_start_hi", 16'(conv_start), 16'd1);
        wait_idle(n);
        check("to_cycles", 16'(n), 16'd65);
        check("to_disp", disp_bcd, 16'hEEEE);
        check("to_err", 16'(err), 16'd1);

        // rdy on the final timeout cycle wins
        set_ops(4'd2, 4'd3, OP_MUL);
        conv_delay = 63;
        press(1'b0, n);
        tick();
        wait_idle(n);
        check("last_cycles", 16'(n), 16'd64);
        check("last_disp", disp_bcd, 16'h0006);
        check("last_err", 16'(err), 16'd0);

        // second press and switch changes while busy are ignored
        set_ops(4'd8, 4'd9, OP_ADD);
        conv_delay = 5;
        s0 = start_cnt;
        press(1'b0, n);
        tick();
        check("busy_conv_bin", conv_bin, 16'h0011);
        set_ops(4'd1, 4'd1, OP_MUL);
        go = 1'b1;
        tick();
        tick();
        go = 1'b0;
        check("busy_disp_hold", disp_bcd, 16'h0006);
        check("busy_valid_hold", 16'(disp_valid), 16'd1);
        wait_idle(n);
        check("busy_disp", disp_bcd, 16'h0017);
        repeat (6) tick();
        check("busy_stay_idle", 16'(busy), 16'd0);
        check("busy_nstart", 16'(start_cnt - s0), 16'd1);
        check("busy_aq", 16'(a_q), 16'd8);

        // reset in WAIT, then a late rdy must not touch the display
        set_ops(4'd2, 4'd2, OP_SUB);
        conv_delay = 10;
        press(1'b0, n);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrst_busy", 16'(busy), 16'd0);
        check("wrst_err", 16'(err), 16'd0);
        check("wrst_valid", 16'(disp_valid), 16'd0);
        check("wrst_disp", disp_bcd, 16'h0000);
        check("wrst_bin", conv_bin, 16'h0000);
        check("wrst_ops", 16'({a_q, b_q, op_q}), 16'd0);
        r0 = rdy_cnt;
        repeat (15) tick();
        check("wrst_rdy_seen", 16'(rdy_cnt - r0), 16'd1);
        check("wrst_disp_late", disp_bcd, 16'h0000);
        check("wrst_valid_late", 16'(disp_valid), 16'd0);

        // go held for 200 cycles gives one sequence
        set_ops(4'd1, 4'd2, OP_ADD);
        conv_delay = 1;
        s0 = start_cnt;
        go = 1'b1;
        repeat (200) tick();
        go = 1'b0;
        repeat (10) tick();
        check("hold_nstart", 16'(start_cnt - s0), 16'd1);
        check("hold_disp", disp_bcd, 16'h0003);
        check("hold_err", 16'(err), 16'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
